data_buffer: RTL and testbench

DATA_BUFFER -- requirements
Module: data_buffer

---
 rtl/data_buffer_pkg.sv | 22 ++
 rtl/data_buffer_ctrl.sv | 116 +++++++++++
 rtl/data_buffer.sv | 53 +++++
 tb/tb_data_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_buffer_pkg.sv
// Shared constants and types for the data_buffer byte FIFO.
// Optional error flags are enabled with the DATA_BUFFER_ERR_FLAGS_EN macro.
package data_buffer_pkg;

  localparam int unsigned BUFFER_DEPTH_MAX = 64;
  localparam int unsigned OCC_W            = 7;

  typedef logic [OCC_W-1:0] occ_t;

  // Encoded as {read_accepted, write_accepted}.
  typedef enum logic [1:0] {
    OpNone  = 2'b00,
    OpWrite = 2'b01,
    OpRead  = 2'b10,
    OpBoth  = 2'b11
  } buf_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_buffer_ctrl.sv
// Pointer, occupancy and error-flag control for data_buffer.
// Error flags are compiled in only when DATA_BUFFER_ERR_FLAGS_EN is defined.
module data_buffer_ctrl
  import data_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store_tx_data,
  input  logic             get_tx_packet_data,
  input  logic             clear,
  output logic             wr_en,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output occ_t             buffer_occupancy,
  output logic             empty,
  output logic             full,
  output logic             overflow_err,
  output logic             underflow_err
);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  occ_t             occ_q, occ_d;
  logic             rd_acc, wr_acc;
  buf_op_e          op;

  // Flags come from the registered count so they never glitch with pointer updates.
  assign empty = (occ_q == '0);
  assign full  = (occ_q == occ_t'(DEPTH));

  assign rd_acc = get_tx_packet_data & ~clear & ~empty;
  // A full buffer still accepts a write when the same cycle frees a slot.
  assign wr_acc = store_tx_data & ~clear & (~full | rd_acc);
  assign op     = buf_op_e'({rd_acc, wr_acc});

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
    end else begin
      unique case (op)
        OpWrite: begin
          wptr_d = wptr_q + PTR_W'(1);
          occ_d  = occ_q + occ_t'(1);
        end
        OpRead: begin
          rptr_d = rptr_q + PTR_W'(1);
          occ_d  = occ_q - occ_t'(1);
        end
        OpBoth: begin
          wptr_d = wptr_q + PTR_W'(1);
          rptr_d = rptr_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

`ifdef DATA_BUFFER_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (store_tx_data && full && !rd_acc) ovf_d = 1'b1;
      if (get_tx_packet_data && empty)      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
`endif

  assign wr_en            = wr_acc;
  assign wptr             = wptr_q;
  assign rptr             = rptr_q;
  assign buffer_occupancy = occ_q;

endmodule

// File: rtl/data_buffer.sv
// Byte FIFO between the AHB slave and USB transmitter, first-word fall-through.
// Define DATA_BUFFER_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module data_buffer
  import data_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       clear,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output occ_t       buffer_occupancy,
  output logic       empty,
  output logic       full,
  output logic       overflow_err,
  output logic       underflow_err
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic             wr_en;
  logic [PTR_W-1:0] wptr, rptr;

  data_buffer_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk                (clk),
    .rst                (rst),
    .store_tx_data      (store_tx_data),
    .get_tx_packet_data (get_tx_packet_data),
    .clear              (clear),
    .wr_en              (wr_en),
    .wptr               (wptr),
    .rptr               (rptr),
    .buffer_occupancy   (buffer_occupancy),
    .empty              (empty),
    .full               (full),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  // Storage is deliberately not reset; emptiness is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= tx_data;
  end

  assign tx_packet_data = empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_data_buffer.sv
// Scoreboard bench for data_buffer: model queue of bytes plus flag model.
module tb_data_buffer;

  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       clear = 1'b0;
  logic       get_tx_packet_data = 1'b0;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       empty, full, overflow_err, underflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  data_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .store_tx_data      (store_tx_data),
    .tx_data            (tx_data),
    .clear              (clear),
    .get_tx_packet_data (get_tx_packet_data),
    .tx_packet_data     (tx_packet_data),
    .buffer_occupancy   (buffer_occupancy),
    .empty              (empty),
    .full               (full),
    .overflow_err       (overflow_err),
    .underflow_err      (underflow_err)
  );

  always #5 clk = ~clk;

  // Called at a negedge; drives one cycle, compares popped bytes, returns at next negedge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr);
    logic rd_ok, wr_ok;
    logic [7:0] exp_b;
    store_tx_data      = w;
    tx_data            = d;
    get_tx_packet_data = r;
    clear              = clr;
    #1;
    rd_ok = r && !clr && (q.size() > 0);
    wr_ok = w && !clr && ((q.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      exp_b = q.pop_front();
      n_tests++;
      if (tx_packet_data !== exp_b) begin
        n_fail++;
        $display("FAIL read_data: got %02h want %02h", tx_packet_data, exp_b);
      end
    end
`ifdef DATA_BUFFER_ERR_FLAGS_EN
    if (clr) begin
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      if (w && !wr_ok) exp_ovf = 1'b1;
      if (r && !rd_ok) exp_unf = 1'b1;
    end
`endif
    if (wr_ok) q.push_back(d);
    if (clr) q.delete();
    @(posedge clk);
    #1;
    store_tx_data      = 1'b0;
    get_tx_packet_data = 1'b0;
    clear              = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_state(input string name);
    logic [7:0] exp_head;
    exp_head = (q.size() > 0) ? q[0] : 8'h00;
    n_tests++;
    if (buffer_occupancy !== 7'(q.size()) || empty !== (q.size() == 0) ||
        full !== (q.size() == DEPTH)) begin
      n_fail++;
      $display("FAIL %s occ: got occ=%0d e=%b f=%b want occ=%0d", name, buffer_occupancy,
               empty, full, q.size());
    end
    n_tests++;
    if (tx_packet_data !== exp_head || overflow_err !== exp_ovf || underflow_err !== exp_unf)
    begin
      n_fail++;
      $display("FAIL %s head/flags: got %02h ovf=%b unf=%b want %02h ovf=%b unf=%b", name,
               tx_packet_data, overflow_err, underflow_err, exp_head, exp_ovf, exp_unf);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (buffer_occupancy !== 7'd0 || empty !== 1'b1 || full !== 1'b0 ||
        tx_packet_data !== 8'h00 || overflow_err !== 1'b0 || underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got occ=%0d e=%b f=%b d=%02h want 0 1 0 00",
               buffer_occupancy, empty, full, tx_packet_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    check_state("reset_prefill");
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if (buffer_occupancy !== 7'd0 || empty !== 1'b1 || tx_packet_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got occ=%0d e=%b d=%02h want 0 1 00",
               buffer_occupancy, empty, tx_packet_data);
    end
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check_state("reset_first_write");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("reset_done");
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check_state("fill_full");
    n_tests++;
    if (full !== 1'b1 || buffer_occupancy !== 7'd64) begin
      n_fail++;
      $display("FAIL fill_flag: got f=%b occ=%0d want 1 64", full, buffer_occupancy);
    end
    for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("drain_empty");
  endtask

  task automatic test_full_boundary();
    for (int i = 1; i <= 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check_state("full_drop");
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    check_state("full_rw");
    for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("full_drained");
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_empty_boundary();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("empty_read");
    step(1'b1, 8'h55, 1'b1, 1'b0);
    check_state("empty_rw");
    n_tests++;
    if (tx_packet_data !== 8'h55 || buffer_occupancy !== 7'd1) begin
      n_fail++;
      $display("FAIL empty_rw_data: got %02h occ=%0d want 55 1", tx_packet_data,
               buffer_occupancy);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("empty_after");
  endtask

  task automatic test_clear();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    check_state("clear_pre");
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    check_state("clear_post");
    step(1'b1, 8'h77, 1'b0, 1'b0);
    check_state("clear_next");
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    check_state("wrap_mid");
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_state("wrap_end");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 60) == 0));
      check_state("b2b");
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_boundary();
    test_empty_boundary();
    test_clear();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
